slot_switch_receiver: RTL and testbench
=======================================

Name: slot_switch_receiver

Overview:
Input-side conditioner for the slot machine's three raw active-low push switches (start/stop). It converts bouncy, asynchronous switch levels into clean one-cycle press/release/long-press events on mainClock. It sits between the board switch pins and the slot system, replacing the direct inversion of the switch inputs. It also generates its own 1 ms debounce tick from the 6 MHz mainClock.

Parameters:
N_SW, 3, number of switch channels
CLK_DIV, 6000, mainClock cycles per debounce tick (1 ms at 6 MHz)
DEBOUNCE_TICKS, 20, consecutive stable ticks required to accept a level change
LONG_TICKS, 1000, ticks held in PRESSED before longPress fires

Ports:
mainClock  input  1  system clock, 6 MHz, the only clock
reset  input  1  asynchronous, active-low reset
switch  input  N_SW  raw board switches, active-low (0 = pressed), asynchronous
swLevel  output  N_SW  debounced level, active-high (1 = pressed)
pressPulse  output  N_SW  one-cycle pulse on accepted press
releasePulse  output  N_SW  one-cycle pulse on accepted release
longPress  output  N_SW  one-cycle pulse once per hold when hold reaches LONG_TICKS
tick  output  1  one-cycle debounce tick strobe

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; tick divider 0; sync flops 1 (released); every channel in UNARMED with debounce and hold counters 0.
- Synchroniser: two flops per bit. rawP[i] = ~sync2[i]. Input-to-decision latency is 2 cycles plus debounce.
- Tick divider: counts 0..CLK_DIV-1 and wraps. tick=1 for exactly the cycle when the counter equals CLK_DIV-1.
- Per-channel FSM. All counting happens only on tick cycles. Channels are fully independent.
  - UNARMED:
    - rawP=0 on tick: dbc+1. rawP=1 (any cycle): dbc=0.
    - dbc reaches DEBOUNCE_TICKS: go to IDLE, dbc=0, no pulse.
    - A switch held through reset therefore never produces a spurious press.
  - IDLE:
    - rawP=1 on tick: dbc+1. rawP=0: dbc=0.
    - dbc reaches DEBOUNCE_TICKS: go to PRESSED, dbc=0, hold=0, pressPulse[i]=1 for one cycle.
  - PRESSED:
    - On each tick, hold increments and saturates at LONG_TICKS.
    - The tick on which hold becomes LONG_TICKS: longPress[i]=1 for one cycle. It never repeats within one hold.
    - rawP=0 on tick: dbc+1. rawP=1: dbc=0.
    - dbc reaches DEBOUNCE_TICKS: go to IDLE, dbc=0, hold=0, releasePulse[i]=1 for one cycle.
- swLevel[i] = 1 exactly while the channel is in PRESSED (registered). It rises in the same cycle as pressPulse and falls in the same cycle as releasePulse.
- Pulses are registered and asserted in the cycle after the deciding tick. Multiple channels may pulse in the same cycle.
- longPress and releasePulse may both fire on one tick only if LONG_TICKS ≤ elapsed ticks. In that case both assert; they are not mutually exclusive.
- Counter widths: dbc holds DEBOUNCE_TICKS; hold holds LONG_TICKS. Neither counter may wrap.
- Reset asserted mid-operation returns everything to the reset state immediately. No pulses are emitted during or on exit from reset.
- Bounce shorter than DEBOUNCE_TICKS consecutive ticks produces no event and no swLevel change.

Test Plan (sim parameters CLK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10):
1. Reset release with switch=3'b111 held for 4 ticks -> all channels reach IDLE after 3 ticks; all outputs stay 0; tick pulses every 4 cycles.
2. switch[0]=0 clean for 5 ticks -> exactly one pressPulse[0] after the 3rd tick following sync; swLevel=3'b001. Release -> one releasePulse[0] 3 ticks later; swLevel=0.
3. switch[1] toggling every 2 ticks for 20 ticks, then settling low -> no pulses during toggling; a single pressPulse[1] 3 ticks after settling.
4. switch[2] held low for 15 ticks -> pressPulse[2], then exactly one longPress[2] 10 ticks later. Nothing further until release, then releasePulse[2].
5. switch=3'b000 held through reset deassertion -> no pressPulse. Release all, then press channel 0 -> normal pressPulse[0].
6. Press channels 0 and 2 on the same cycle -> pressPulse=3'b101 in one cycle. Assert reset mid-hold -> outputs 0 immediately and no longPress.

Source files
------------

// File: rtl/slot_switch_receiver.sv
// rtl/slot_switch_receiver.sv - synchronise, debounce and event-detect the active-low slot switches
module slot_switch_receiver #(
    parameter int N_SW           = 3,
    parameter int CLK_DIV        = 6000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000
) (
    input  logic            mainClock,
    input  logic            reset,
    input  logic [N_SW-1:0] switch,
    output logic [N_SW-1:0] swLevel,
    output logic [N_SW-1:0] pressPulse,
    output logic [N_SW-1:0] releasePulse,
    output logic [N_SW-1:0] longPress,
    output logic            tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam int HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS + 1) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_TICKS);

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2
    } ch_state_t;

    logic [CW-1:0]   div_cnt;
    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    logic [N_SW-1:0] rawp;
    ch_state_t       st   [N_SW];
    logic [DW-1:0]   dbc  [N_SW];
    logic [HW-1:0]   hold [N_SW];

    assign rawp = ~sync2;
    assign tick = (div_cnt == DIV_LAST);

    // Sync flops reset to the released level so a switch held through reset looks released at first
    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            sync1   <= '1;
            sync2   <= '1;
            div_cnt <= '0;
        end else begin
            sync1   <= switch;
            sync2   <= sync1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            swLevel      <= '0;
            pressPulse   <= '0;
            releasePulse <= '0;
            longPress    <= '0;
            for (int i = 0; i < N_SW; i++) begin
                st[i]   <= UNARMED;
                dbc[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            pressPulse   <= '0;
            releasePulse <= '0;
            longPress    <= '0;
            for (int i = 0; i < N_SW; i++) begin
                case (st[i])
                    // Must see a stable release before arming, so a stuck or held switch stays silent
                    UNARMED: begin
                        if (rawp[i]) begin
                            dbc[i] <= '0;
                        end else if (tick) begin
                            if (dbc[i] == DEB_LAST) begin
                                st[i]  <= IDLE;
                                dbc[i] <= '0;
                            end else begin
                                dbc[i] <= dbc[i] + 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        if (!rawp[i]) begin
                            dbc[i] <= '0;
                        end else if (tick) begin
                            if (dbc[i] == DEB_LAST) begin
                                st[i]         <= PRESSED;
                                dbc[i]        <= '0;
                                hold[i]       <= '0;
                                pressPulse[i] <= 1'b1;
                                swLevel[i]    <= 1'b1;
                            end else begin
                                dbc[i] <= dbc[i] + 1'b1;
                            end
                        end
                    end
                    PRESSED: begin
                        if (tick) begin
                            if (hold[i] != LONG_MAX) begin
                                hold[i] <= hold[i] + 1'b1;
                            end
                            if (hold[i] == LONG_LAST) begin
                                longPress[i] <= 1'b1;
                            end
                        end
                        // Release handling comes last so its hold clear wins over the increment
                        if (rawp[i]) begin
                            dbc[i] <= '0;
                        end else if (tick) begin
                            if (dbc[i] == DEB_LAST) begin
                                st[i]           <= IDLE;
                                dbc[i]          <= '0;
                                hold[i]         <= '0;
                                releasePulse[i] <= 1'b1;
                                swLevel[i]      <= 1'b0;
                            end else begin
                                dbc[i] <= dbc[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        st[i]   <= UNARMED;
                        dbc[i]  <= '0;
                        hold[i] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slot_switch_receiver.sv
// tb/tb_slot_switch_receiver.sv - directed self-checking bench for slot_switch_receiver
module tb_slot_switch_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'b111;
    logic [2:0] sw_level;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] long_press;
    logic       tick;

    int total = 0;
    int bad = 0;

    int press_n [3] = '{0, 0, 0};
    int rel_n   [3] = '{0, 0, 0};
    int long_n  [3] = '{0, 0, 0};
    int tick_n  = 0;
    int dual_n  = 0;

    int s_tick, s_p0, s_p1, s_p2, s_r0, s_r1, s_r2, s_l2, s_lall, s_pall, s_dual;

    slot_switch_receiver #(
        .N_SW(3),
        .CLK_DIV(4),
        .DEBOUNCE_TICKS(3),
        .LONG_TICKS(10)
    ) u_dut (
        .mainClock   (clk),
        .reset       (rst_n),
        .switch      (sw),
        .swLevel     (sw_level),
        .pressPulse  (press_pulse),
        .releasePulse(release_pulse),
        .longPress   (long_press),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_n = tick_n + int'(tick);
        if (press_pulse == 3'b101) dual_n = dual_n + 1;
        for (int i = 0; i < 3; i++) begin
            press_n[i] = press_n[i] + int'(press_pulse[i]);
            rel_n[i]   = rel_n[i] + int'(release_pulse[i]);
            long_n[i]  = long_n[i] + int'(long_press[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Lands just before a tick edge; inputs driven here are sampled by that edge
    task automatic align();
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!tick && k < 20);
        check("align_tick", 32'(tick), 32'd1);
    endtask

    function automatic int sum3(input int a, input int b, input int c);
        return a + b + c;
    endfunction

    initial begin
        // reset state
        step(3);
        check("rst_level", 32'(sw_level), 32'd0);
        check("rst_press", 32'(press_pulse), 32'd0);
        check("rst_release", 32'(release_pulse), 32'd0);
        check("rst_long", 32'(long_press), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        // 1: released switches arm silently, tick every 4 cycles
        s_tick = tick_n;
        s_pall = sum3(press_n[0], press_n[1], press_n[2]) + sum3(rel_n[0], rel_n[1], rel_n[2])
               + sum3(long_n[0], long_n[1], long_n[2]);
        step(40);
        check("t1_ticks", 32'(tick_n - s_tick), 32'd10);
        check("t1_events", 32'(sum3(press_n[0], press_n[1], press_n[2]) + sum3(rel_n[0], rel_n[1], rel_n[2])
              + sum3(long_n[0], long_n[1], long_n[2]) - s_pall), 32'd0);
        check("t1_level", 32'(sw_level), 32'd0);

        // 2: clean press / release on channel 0
        align();
        sw[0] = 1'b0;
        s_p0 = press_n[0];
        step(12);
        check("t2_press_early", 32'(press_pulse), 32'd0);
        check("t2_level_early", 32'(sw_level), 32'd0);
        step(1);
        check("t2_press", 32'(press_pulse), 32'b001);
        check("t2_level", 32'(sw_level), 32'b001);
        step(1);
        check("t2_press_width", 32'(press_pulse), 32'd0);
        step(20);
        check("t2_press_count", 32'(press_n[0] - s_p0), 32'd1);
        align();
        sw[0] = 1'b1;
        s_r0 = rel_n[0];
        step(12);
        check("t2_level_hold", 32'(sw_level), 32'b001);
        step(1);
        check("t2_release", 32'(release_pulse), 32'b001);
        check("t2_level_low", 32'(sw_level), 32'd0);
        step(8);
        check("t2_release_count", 32'(rel_n[0] - s_r0), 32'd1);

        // 3: bounce of 2 ticks per level is rejected, then settle low
        align();
        s_p1 = press_n[1];
        for (int k = 0; k < 10; k++) begin
            sw[1] = k[0];
            step(8);
        end
        check("t3_bounce_press", 32'(press_n[1] - s_p1), 32'd0);
        check("t3_bounce_level", 32'(sw_level), 32'd0);
        sw[1] = 1'b0;
        step(12);
        check("t3_settle_early", 32'(press_n[1] - s_p1), 32'd0);
        step(1);
        check("t3_settle_press", 32'(press_pulse), 32'b010);
        align();
        sw[1] = 1'b1;
        step(20);
        check("t3_level_low", 32'(sw_level), 32'd0);

        // 4: long press on channel 2 fires once, 10 ticks after press
        align();
        sw[2] = 1'b0;
        s_l2 = long_n[2];
        s_r2 = rel_n[2];
        step(13);
        check("t4_press", 32'(press_pulse), 32'b100);
        step(39);
        check("t4_long_early", 32'(long_n[2] - s_l2), 32'd0);
        step(1);
        check("t4_long", 32'(long_press), 32'b100);
        step(1);
        check("t4_long_width", 32'(long_press), 32'd0);
        step(60);
        check("t4_long_once", 32'(long_n[2] - s_l2), 32'd1);
        check("t4_level_held", 32'(sw_level), 32'b100);
        check("t4_no_release", 32'(rel_n[2] - s_r2), 32'd0);
        align();
        sw[2] = 1'b1;
        step(13);
        check("t4_release", 32'(release_pulse), 32'b100);
        check("t4_level_low", 32'(sw_level), 32'd0);

        // 5: switches held through reset never press; normal press afterwards
        sw = 3'b000;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        s_pall = sum3(press_n[0], press_n[1], press_n[2]);
        step(120);
        check("t5_held_press", 32'(sum3(press_n[0], press_n[1], press_n[2]) - s_pall), 32'd0);
        check("t5_held_level", 32'(sw_level), 32'd0);
        align();
        sw = 3'b111;
        step(20);
        align();
        sw[0] = 1'b0;
        step(13);
        check("t5_press", 32'(press_pulse), 32'b001);
        check("t5_press_total", 32'(sum3(press_n[0], press_n[1], press_n[2]) - s_pall), 32'd1);

        // 6: simultaneous press, then reset mid-hold
        align();
        sw = 3'b111;
        step(20);
        s_dual = dual_n;
        align();
        sw = 3'b010;
        step(13);
        check("t6_dual_press", 32'(press_pulse), 32'b101);
        check("t6_dual_level", 32'(sw_level), 32'b101);
        step(20);
        s_lall = sum3(long_n[0], long_n[1], long_n[2]);
        s_pall = sum3(press_n[0], press_n[1], press_n[2]);
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", 32'(sw_level), 32'd0);
        check("t6_rst_press", 32'(press_pulse), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(240);
        check("t6_dual_count", 32'(dual_n - s_dual), 32'd1);
        check("t6_no_long", 32'(sum3(long_n[0], long_n[1], long_n[2]) - s_lall), 32'd0);
        check("t6_no_press", 32'(sum3(press_n[0], press_n[1], press_n[2]) - s_pall), 32'd0);
        check("t6_level_after", 32'(sw_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
